// File: rtl/mini_alu_pkg.sv
// Shared types for the mini ALU instruction path: instruction word layout,
// opcode encoding and the sequencer FSM state encoding.
package mini_alu_pkg;

    localparam int INSTR_W = 8;

    typedef enum logic [1:0] {
        LOADL = 2'b00,
        LOADH = 2'b01,
        ADD   = 2'b10,
        SUB   = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] x;
        logic [1:0] y;
        logic [1:0] z;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_OFFER = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

endpackage

// File: rtl/mini_alu_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// pulse when a new high level is accepted. Falling levels are accepted
// silently (no pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q, last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // Synchroniser chain plus the previous synced sample for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
        end
    end

    // Stability counter restarts on every synced change; saturates at the
    // acceptance threshold so a held level never re-triggers.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != last_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((sync2_q == last_q) && (cnt_q == CNT_LAST) && (sync2_q != level_q)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
        end
    end

    // Counter, accepted level and rise pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/mini_alu_sequencer.sv
// Instruction source for the mini ALU: program RAM walked by a PC, one
// instruction offered per step (button or run-mode tick).
//
// Handshake: instr_valid rises only in OFFER and stays high with instr held
// stable until a clk edge sees instr_valid & instr_ready; instr_valid never
// drops without that transfer except on rst.
module mini_alu_sequencer
    import mini_alu_pkg::*;
#(
    parameter int PROG_LEN        = 16,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int RUN_DIV         = 12000000,
    localparam int AW             = $clog2(PROG_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_step,
    input  logic               btn_run,
    input  logic               btn_rewind,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic [AW:0]        prog_len,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [AW-1:0]      pc,
    output logic               running,
    output logic               halted,
    output state_e             state_dbg
);

    localparam int RW = $clog2(RUN_DIV);
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_DIV - 1);

    logic               step_pulse, run_pulse, rew_pulse;
    logic [2:0]         btn_levels_unused;
    logic               run_tick, step_req;

    logic [INSTR_W-1:0] mem_q [PROG_LEN];

    state_e             state_q, state_d;
    logic [AW:0]        pc_q, pc_d;           // one extra bit so pc can reach PROG_LEN
    instr_t             instr_q, instr_d;
    logic               rew_pend_q, rew_pend_d;
    logic               running_q, running_d;
    logic [RW-1:0]      run_cnt_q, run_cnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
        .clk(clk), .rst(rst), .btn_raw(btn_step),
        .level(btn_levels_unused[0]), .rise_pulse(step_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
        .clk(clk), .rst(rst), .btn_raw(btn_run),
        .level(btn_levels_unused[1]), .rise_pulse(run_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rew (
        .clk(clk), .rst(rst), .btn_raw(btn_rewind),
        .level(btn_levels_unused[2]), .rise_pulse(rew_pulse)
    );

    assign run_tick = running_q && (run_cnt_q == RUN_LAST);
    assign step_req = step_pulse | run_tick;

    // Program RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    // Next-state logic: FSM, PC, run mode, pending rewind, instruction latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rew_pend_d = rew_pend_q;
        running_d  = running_q;
        run_cnt_d  = run_cnt_q;

        if (!running_q || run_tick || run_pulse) begin
            run_cnt_d = '0;
        end else begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        if (run_pulse && (state_q != ST_HALT)) begin
            running_d = !running_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rew_pulse) begin
                    pc_d = '0;
                end else if (step_req) begin
                    state_d = (pc_q >= prog_len) ? ST_HALT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Combinational read of the pre-edge array gives read-first behaviour.
                instr_d = instr_t'(mem_q[pc_q[AW-1:0]]);
                state_d = ST_OFFER;
                if (rew_pulse) rew_pend_d = 1'b1;
            end
            ST_OFFER: begin
                if (rew_pulse) rew_pend_d = 1'b1;
                if (instr_ready) begin
                    state_d    = ST_IDLE;
                    rew_pend_d = 1'b0;
                    pc_d       = (rew_pulse || rew_pend_q) ? '0 : pc_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (rew_pulse) begin
                    pc_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_HALT) begin
            running_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            rew_pend_q <= 1'b0;
            running_q  <= 1'b0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rew_pend_q <= rew_pend_d;
            running_q  <= running_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_OFFER);
    assign halted      = (state_q == ST_HALT);
    assign running     = running_q;
    assign pc          = pc_q[AW-1:0];
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Directed bench for mini_alu_sequencer with short debounce and run period.
module tb_mini_alu_sequencer;
    import mini_alu_pkg::*;

    localparam int PROG_LEN = 16;
    localparam int DEB      = 4;
    localparam int RUN_DIV  = 16;
    localparam int AW       = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_step = 1'b0, btn_run = 1'b0, btn_rewind = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [7:0]    prog_wdata = '0;
    logic [AW:0]   prog_len = '0;
    logic [7:0]    instr;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] pc;
    logic          running, halted;
    state_e        state_dbg;

    int checks = 0;
    int errors = 0;

    mini_alu_sequencer #(
        .PROG_LEN(PROG_LEN), .DEBOUNCE_CYCLES(DEB), .RUN_DIV(RUN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run),
        .btn_rewind(btn_rewind), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .running(running), .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [7:0] d);
        prog_addr  = a;
        prog_wdata = d;
        prog_we    = 1'b1;
        tick();
        prog_we    = 1'b0;
    endtask

    // Wait (bounded) for a debounced rise pulse: 0=step 1=run 2=rewind.
    task automatic wait_pulse(input int which, input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((which == 0 && dut.step_pulse) || (which == 1 && dut.run_pulse) ||
                (which == 2 && dut.rew_pulse)) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: pulse seen=0 required=1", name);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_valid) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: instr_valid seen=0 required=1", name);
        end
    endtask

    task automatic press_rewind();
        btn_rewind = 1'b1;
        wait_pulse(2, "rewind_pulse");
        tick();
        btn_rewind = 1'b0;
        ticks(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        checks++;
        if ({pc, instr, instr_valid, running, halted} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h instr=%h v=%b run=%b halt=%b required all 0",
                     pc, instr, instr_valid, running, halted);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_single_step();
        write_word(0, 8'h07);
        write_word(1, 8'h43);
        write_word(2, 8'h92);
        prog_len    = 3;
        instr_ready = 1'b1;
        btn_step    = 1'b1;
        wait_pulse(0, "step_pulse");
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL step_lat_n1: valid=%b required 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 8'h07 || pc !== 4'd0) begin
            errors++;
            $display("FAIL step_lat_n2: valid=%b instr=%h pc=%0d required 1 07 0", instr_valid, instr, pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd1) begin
            errors++;
            $display("FAIL step_done: valid=%b pc=%0d required 0 1", instr_valid, pc);
        end
        btn_step = 1'b0;
        ticks(12);
    endtask

    task automatic test_bouncy();
        int offers = 0;
        logic [7:0] last = '0;
        for (int i = 0; i < 10; i++) begin
            btn_step = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick();
                if (instr_valid) begin offers++; last = instr; end
            end
        end
        btn_step = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (instr_valid) begin offers++; last = instr; end
        end
        btn_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (instr_valid) begin offers++; last = instr; end
        end
        checks++;
        if (offers !== 1 || last !== 8'h43 || pc !== 4'd2) begin
            errors++;
            $display("FAIL bouncy_once: offers=%0d instr=%h pc=%0d required 1 43 2", offers, last, pc);
        end
    endtask

    task automatic test_backpressure();
        bit held_ok = 1;
        int late = 0;
        press_rewind();
        checks++;
        if (pc !== 4'd0) begin
            errors++;
            $display("FAIL bp_rewind: pc=%0d required 0", pc);
        end
        btn_step = 1'b1;
        wait_valid("bp_first_valid");
        checks++;
        if (instr !== 8'h07) begin
            errors++;
            $display("FAIL bp_first_instr: got %h required 07", instr);
        end
        btn_step = 1'b0;
        ticks(12);
        instr_ready = 1'b0;
        btn_step = 1'b1;
        wait_valid("bp_second_valid");
        btn_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!instr_valid || instr !== 8'h43) held_ok = 0;
        end
        write_word(1, 8'hFF);
        btn_step = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!instr_valid || instr !== 8'h43) held_ok = 0;
        end
        write_word(1, 8'h43);
        checks++;
        if (!held_ok || instr !== 8'h43 || instr_valid !== 1'b1 || pc !== 4'd1) begin
            errors++;
            $display("FAIL bp_hold: held_ok=%b instr=%h valid=%b pc=%0d required 1 43 1 1",
                     held_ok, instr, instr_valid, pc);
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd2) begin
            errors++;
            $display("FAIL bp_accept: valid=%b pc=%0d required 0 2", instr_valid, pc);
        end
        btn_step = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (instr_valid) late++;
        end
        checks++;
        if (late !== 0 || pc !== 4'd2) begin
            errors++;
            $display("FAIL bp_dropped: late_valid=%0d pc=%0d required 0 2", late, pc);
        end
    endtask

    task automatic test_run();
        logic [7:0] got [$];
        int t [$];
        bit ok;
        press_rewind();
        instr_ready = 1'b1;
        btn_run = 1'b1;
        wait_pulse(1, "run_pulse");
        btn_run = 1'b0;
        tick();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL run_on: running=%b required 1", running);
        end
        for (int i = 0; i < 150; i++) begin
            tick();
            if (instr_valid) begin got.push_back(instr); t.push_back(i); end
            if (halted) break;
        end
        ok = (got.size() == 3);
        if (ok) ok = (got[0] == 8'h07) && (got[1] == 8'h43) && (got[2] == 8'h92) &&
                     (t[1] - t[0] == RUN_DIV) && (t[2] - t[1] == RUN_DIV);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run_sequence: offers=%0d required 3 (07,43,92 spaced %0d)", got.size(), RUN_DIV);
        end
        checks++;
        if (halted !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL run_halt: halted=%b running=%b required 1 0", halted, running);
        end
        ticks(12);
        btn_run = 1'b1;
        wait_pulse(1, "run_pulse_halted");
        ticks(2);
        checks++;
        if (running !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL run_ignored: running=%b halted=%b required 0 1", running, halted);
        end
        btn_run = 1'b0;
        ticks(12);
    endtask

    task automatic test_rewind();
        btn_rewind = 1'b1;
        wait_pulse(2, "rewind_halt_pulse");
        tick();
        checks++;
        if (halted !== 1'b0 || pc !== 4'd0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL rewind_halt: halted=%b pc=%0d state=%0d required 0 0 0", halted, pc, state_dbg);
        end
        btn_rewind = 1'b0;
        ticks(12);
        instr_ready = 1'b0;
        btn_step = 1'b1;
        wait_valid("rw_offer_valid");
        btn_step = 1'b0;
        ticks(12);
        btn_rewind = 1'b1;
        wait_pulse(2, "rewind_offer_pulse");
        ticks(3);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 8'h07) begin
            errors++;
            $display("FAIL rewind_no_abort: valid=%b instr=%h required 1 07", instr_valid, instr);
        end
        btn_rewind = 1'b0;
        ticks(12);
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0) begin
            errors++;
            $display("FAIL rewind_pending: valid=%b pc=%0d required 0 0", instr_valid, pc);
        end
        btn_step = 1'b1;
        wait_valid("rw_restart_valid");
        checks++;
        if (instr !== 8'h07) begin
            errors++;
            $display("FAIL rewind_restart: instr=%h required 07", instr);
        end
        btn_step = 1'b0;
        ticks(12);
    endtask

    task automatic test_empty_and_reset();
        int vcount = 0;
        prog_len = 0;
        press_rewind();
        btn_step = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_valid) vcount++;
            if (halted) break;
        end
        checks++;
        if (halted !== 1'b1 || vcount !== 0) begin
            errors++;
            $display("FAIL empty_halt: halted=%b valid_cycles=%0d required 1 0", halted, vcount);
        end
        btn_step = 1'b0;
        ticks(12);
        press_rewind();
        prog_len    = 3;
        instr_ready = 1'b1;
        btn_step = 1'b1;
        wait_valid("rst_first_valid");
        btn_step = 1'b0;
        ticks(12);
        instr_ready = 1'b0;
        btn_step = 1'b1;
        wait_valid("rst_second_valid");
        btn_step = 1'b0;
        checks++;
        if (instr !== 8'h43 || pc !== 4'd1) begin
            errors++;
            $display("FAIL rst_pre: instr=%h pc=%0d required 43 1", instr, pc);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0 || halted !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b pc=%0d halted=%b running=%b required 0 0 0 0",
                     instr_valid, pc, halted, running);
        end
        ticks(2);
        rst = 1'b0;
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: state=%0d valid=%b required 0 0", state_dbg, instr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_bouncy();
        test_backpressure();
        test_run();
        test_rewind();
        test_empty_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
